// File: rtl/i2c_inst_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_inst_bridge_if
// Description : Bus bundle for i2c_inst_bridge. It carries the I2C slave
//               register-side signals (address/data registers in, readback
//               out) and the core instruction read port. The master modport
//               is the driving side (slave register block plus core). The
//               slave modport is the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_inst_bridge_if #(
  parameter int ADDR_W = 4
);
  // I2C slave register side (SCL domain levels in, readback out)
  logic [7:0]        i2c_addr_reg;
  logic [7:0]        i2c_data_reg;
  logic [7:0]        i2c_read_data;

  // Core instruction read port
  logic              core_rd_en;
  logic [ADDR_W-1:0] core_rd_addr;
  logic [7:0]        core_rd_data;

  modport master (
    output i2c_addr_reg,
    output i2c_data_reg,
    output core_rd_en,
    output core_rd_addr,
    input  i2c_read_data,
    input  core_rd_data
  );

  modport slave (
    input  i2c_addr_reg,
    input  i2c_data_reg,
    input  core_rd_en,
    input  core_rd_addr,
    output i2c_read_data,
    output core_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/i2c_inst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_inst_bridge
// Description : Resynchronises the I2C slave address/data registers into the
//               clk domain and filters them for stability. Each stable change
//               of the data register is committed into a small instruction
//               memory. Two read paths are provided: mem[address] back to the
//               slave readback register, and a registered read port for the
//               core.
//               Optional build macro INST_PARITY_EN adds a stored even-parity
//               bit per entry, a sticky parity_err output and a test-only
//               parity_flip input.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_inst_bridge #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_inst_bridge_if.slave    bus,
  output logic                wr_pulse,
  output logic [7:0]          wr_count
`ifdef INST_PARITY_EN
  ,
  input  logic                parity_flip,
  output logic                parity_err
`endif
);

  // Index width of the memory array; at least one bit.
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Settle counter only has to reach STABLE_CYCLES-1.
  localparam int CNT_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef INST_PARITY_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  // Commit FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]         addr_meta;
  logic [7:0]         data_meta;
  logic [7:0]         s_addr;
  logic [7:0]         s_data;

  logic [1:0]         state;
  logic [7:0]         cand;
  logic [7:0]         cand_addr;
  logic [7:0]         last_data;
  logic [CNT_W-1:0]   cnt;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [7:0]         read_data_q;
  logic [7:0]         core_data_q;

  logic               cand_in_range;
  logic               s_addr_in_range;
  logic               core_in_range;
  logic [MEM_AW-1:0]  cand_idx;
  logic [MEM_AW-1:0]  s_idx;
  logic [MEM_AW-1:0]  core_idx;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] core_entry;

  // --------------------------------------------------------------------------
  // Address decode. Comparisons are done on the full width so that
  // addresses beyond DEPTH are rejected rather than aliased.
  // --------------------------------------------------------------------------
  assign cand_in_range   = (int'(cand_addr)        < DEPTH);
  assign s_addr_in_range = (int'(s_addr)           < DEPTH);
  assign core_in_range   = (int'(bus.core_rd_addr) < DEPTH);
  assign cand_idx        = cand_addr[MEM_AW-1:0];
  assign s_idx           = s_addr[MEM_AW-1:0];
  assign core_idx        = bus.core_rd_addr[MEM_AW-1:0];
  assign core_entry      = mem[core_idx];

`ifdef INST_PARITY_EN
  // Even parity over the data byte; parity_flip deliberately corrupts it.
  assign wr_entry = {(^cand) ^ parity_flip, cand};
`else
  assign wr_entry = cand;
`endif

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for both SCL-domain register buses. Bit skew
  // between the lanes is tolerated because the FSM only commits a value that
  // has been stable for STABLE_CYCLES.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_meta <= 8'h00;
      data_meta <= 8'h00;
      s_addr    <= 8'h00;
      s_data    <= 8'h00;
    end else begin
      addr_meta <= bus.i2c_addr_reg;
      data_meta <= bus.i2c_data_reg;
      s_addr    <= addr_meta;
      s_data    <= data_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter and commit FSM. Only a change of the data register
  // starts a commit; address-only changes are tracked while settling but
  // never trigger one. last_data starts at the slave's reset value so that
  // leaving reset does not produce a write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 8'h00;
      cand_addr <= 8'h00;
      last_data <= 8'h00;
      cnt       <= '0;
      wr_pulse  <= 1'b0;
      wr_count  <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s_data != last_data) begin
            cand      <= s_data;
            cand_addr <= s_addr;
            cnt       <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if ((s_data != cand) || (s_addr != cand_addr)) begin
            cand      <= s_data;
            cand_addr <= s_addr;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            // The strobe is raised for exactly the COMMIT cycle.
            wr_pulse <= 1'b1;
            state    <= COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          // Counted even when the address is out of range and the write is dropped.
          last_data <= cand;
          wr_count  <= wr_count + 8'd1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction memory: cleared on reset, written once per in-range commit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == COMMIT) && cand_in_range) begin
      mem[cand_idx] <= wr_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Slave readback: mem[s_addr] refreshed every cycle, 0x00 when unmapped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= 8'h00;
    end else if (s_addr_in_range) begin
      read_data_q <= mem[s_idx][7:0];
    end else begin
      read_data_q <= 8'h00;
    end
  end

  // --------------------------------------------------------------------------
  // Core read port: registered, holds while core_rd_en is low. It samples the
  // array before any same-cycle commit lands, so a collision returns the old
  // entry.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_data_q <= 8'h00;
    end else if (bus.core_rd_en) begin
      core_data_q <= core_in_range ? core_entry[7:0] : 8'h00;
    end
  end

`ifdef INST_PARITY_EN
  // --------------------------------------------------------------------------
  // Sticky parity error: set when the core reads an entry whose 9-bit
  // contents do not have even parity; cleared only by reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (bus.core_rd_en && core_in_range && (^core_entry)) begin
      parity_err <= 1'b1;
    end
  end
`endif

  assign bus.i2c_read_data = read_data_q;
  assign bus.core_rd_data  = core_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_inst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_inst_bridge
// Description : Directed self-checking bench for i2c_inst_bridge
//               (DEPTH=16, ADDR_W=4, STABLE_CYCLES=4). Parity scenario is
//               built only with INST_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_inst_bridge;

  logic       clk;
  logic       rst_n;
  logic       wr_pulse;
  logic [7:0] wr_count;
`ifdef INST_PARITY_EN
  logic       parity_flip;
  logic       parity_err;
`endif

  int n_checks;
  int n_fail;

  i2c_inst_bridge_if #(.ADDR_W(4)) bus ();

  i2c_inst_bridge #(
    .DEPTH        (16),
    .ADDR_W       (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .wr_pulse (wr_pulse),
    .wr_count (wr_count)
`ifdef INST_PARITY_EN
    ,
    .parity_flip(parity_flip),
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts wr_pulse over n cycles; first = cycle index (1-based) of first pulse.
  task automatic watch(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (wr_pulse) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset_initial;
    rst_n = 1'b0;
    bus.i2c_addr_reg = 8'h00;
    bus.i2c_data_reg = 8'h00;
    bus.core_rd_en   = 1'b0;
    bus.core_rd_addr = 4'h0;
`ifdef INST_PARITY_EN
    parity_flip = 1'b0;
`endif
    step(3);
    n_checks++;
    if (wr_pulse !== 1'b0 || wr_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: wr_pulse=%b wr_count=%h expected 0/00", wr_pulse, wr_count);
    end
    n_checks++;
    if (bus.i2c_read_data !== 8'h00 || bus.core_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: read=%h core=%h expected 00/00", bus.i2c_read_data, bus.core_rd_data);
    end
`ifdef INST_PARITY_EN
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity: got %b expected 0", parity_err);
    end
`endif
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic_write;
    int p, f;
    bus.i2c_addr_reg = 8'h03;
    watch(4, p, f);
    n_checks++;
    if (p !== 0) begin
      n_fail++;
      $display("FAIL addr_only_no_commit: pulses=%0d expected 0", p);
    end
    bus.i2c_data_reg = 8'h57;
    watch(12, p, f);
    n_checks++;
    if (p !== 1 || f !== 7) begin
      n_fail++;
      $display("FAIL basic_pulse: pulses=%0d at cycle %0d expected 1 at 7", p, f);
    end
    n_checks++;
    if (wr_count !== 8'h01) begin
      n_fail++;
      $display("FAIL basic_count: got %h expected 01", wr_count);
    end
    n_checks++;
    if (bus.i2c_read_data !== 8'h57) begin
      n_fail++;
      $display("FAIL basic_readback: got %h expected 57", bus.i2c_read_data);
    end
    bus.core_rd_en   = 1'b1;
    bus.core_rd_addr = 4'h3;
    step(1);
    n_checks++;
    if (bus.core_rd_data !== 8'h57) begin
      n_fail++;
      $display("FAIL basic_core_read: got %h expected 57", bus.core_rd_data);
    end
    bus.core_rd_en   = 1'b0;
    bus.core_rd_addr = 4'h0;
    step(2);
    n_checks++;
    if (bus.core_rd_data !== 8'h57) begin
      n_fail++;
      $display("FAIL core_hold: got %h expected 57", bus.core_rd_data);
    end
  endtask

  task automatic test_glitch_filter;
    int p, f, total;
    bus.i2c_addr_reg = 8'h07;
    watch(6, p, f);
    total = p;
    bus.i2c_data_reg = 8'h10;
    watch(2, p, f);
    total += p;
    bus.i2c_data_reg = 8'h11;
    watch(2, p, f);
    total += p;
    bus.i2c_data_reg = 8'h12;
    watch(15, p, f);
    total += p;
    n_checks++;
    if (total !== 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 1", total);
    end
    n_checks++;
    if (wr_count !== 8'h02) begin
      n_fail++;
      $display("FAIL glitch_count: got %h expected 02", wr_count);
    end
    bus.core_rd_en   = 1'b1;
    bus.core_rd_addr = 4'h7;
    step(1);
    bus.core_rd_en   = 1'b0;
    n_checks++;
    if (bus.core_rd_data !== 8'h12) begin
      n_fail++;
      $display("FAIL glitch_value: got %h expected 12", bus.core_rd_data);
    end
    n_checks++;
    if (bus.i2c_read_data !== 8'h12) begin
      n_fail++;
      $display("FAIL glitch_readback: got %h expected 12", bus.i2c_read_data);
    end
  endtask

  task automatic test_out_of_range;
    int p, f;
    bus.i2c_addr_reg = 8'h20;
    step(4);
    bus.i2c_data_reg = 8'hA5;
    watch(12, p, f);
    n_checks++;
    if (p !== 1) begin
      n_fail++;
      $display("FAIL oor_pulse: got %0d expected 1", p);
    end
    n_checks++;
    if (wr_count !== 8'h03) begin
      n_fail++;
      $display("FAIL oor_count: got %h expected 03", wr_count);
    end
    n_checks++;
    if (bus.i2c_read_data !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_readback: got %h expected 00", bus.i2c_read_data);
    end
    // 0x20 must not alias onto entry 0.
    bus.core_rd_en   = 1'b1;
    bus.core_rd_addr = 4'h0;
    step(1);
    n_checks++;
    if (bus.core_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_alias: entry0 got %h expected 00", bus.core_rd_data);
    end
    bus.core_rd_addr = 4'h3;
    step(1);
    bus.core_rd_en   = 1'b0;
    n_checks++;
    if (bus.core_rd_data !== 8'h57) begin
      n_fail++;
      $display("FAIL oor_mem_intact: entry3 got %h expected 57", bus.core_rd_data);
    end
  endtask

  task automatic test_collision_wrap;
    int  p, f, total;
    bit  seen;
    bus.i2c_addr_reg = 8'h05;
    step(4);
    bus.i2c_data_reg = 8'h66;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_pulse) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL collision_pulse: no wr_pulse within 20 cycles expected 1");
    end else begin
      // Read the entry on the very edge that commits it.
      bus.core_rd_en   = 1'b1;
      bus.core_rd_addr = 4'h5;
      step(1);
      n_checks++;
      if (bus.core_rd_data !== 8'h00) begin
        n_fail++;
        $display("FAIL collision_old: got %h expected 00", bus.core_rd_data);
      end
      step(1);
      n_checks++;
      if (bus.core_rd_data !== 8'h66) begin
        n_fail++;
        $display("FAIL collision_new: got %h expected 66", bus.core_rd_data);
      end
      bus.core_rd_en = 1'b0;
    end
    step(2);
    n_checks++;
    if (wr_count !== 8'h04) begin
      n_fail++;
      $display("FAIL collision_count: got %h expected 04", wr_count);
    end
    // 251 more commits take the counter to 0xFF, one more wraps it.
    bus.i2c_addr_reg = 8'h30;
    step(4);
    total = 0;
    for (int k = 0; k < 251; k++) begin
      bus.i2c_data_reg = (k % 2 == 0) ? 8'h01 : 8'h02;
      watch(10, p, f);
      total += p;
    end
    n_checks++;
    if (total !== 251) begin
      n_fail++;
      $display("FAIL wrap_pulses: got %0d expected 251", total);
    end
    n_checks++;
    if (wr_count !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_ff: got %h expected ff", wr_count);
    end
    bus.i2c_data_reg = 8'h02;
    watch(10, p, f);
    n_checks++;
    if (wr_count !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h expected 00", wr_count);
    end
  endtask

  task automatic test_reset_mid_settle;
    int  p, f;
    bit  nonzero;
    bus.i2c_addr_reg = 8'h04;
    step(4);
    bus.i2c_data_reg = 8'h99;
    step(4);
    rst_n = 1'b0;
    bus.i2c_addr_reg = 8'h00;
    bus.i2c_data_reg = 8'h00;
    bus.core_rd_en   = 1'b0;
    bus.core_rd_addr = 4'h0;
    step(1);
    n_checks++;
    if (wr_pulse !== 1'b0 || wr_count !== 8'h00 ||
        bus.i2c_read_data !== 8'h00 || bus.core_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outputs: pulse=%b count=%h read=%h core=%h expected all 0",
               wr_pulse, wr_count, bus.i2c_read_data, bus.core_rd_data);
    end
    rst_n = 1'b1;
    nonzero = 1'b0;
    bus.core_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.core_rd_addr = 4'(i);
      step(1);
      if (bus.core_rd_data !== 8'h00) nonzero = 1'b1;
    end
    bus.core_rd_en = 1'b0;
    n_checks++;
    if (nonzero) begin
      n_fail++;
      $display("FAIL midreset_mem: some entry read nonzero expected all 00");
    end
    watch(12, p, f);
    n_checks++;
    if (p !== 0 || wr_count !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_no_write: pulses=%0d count=%h expected 0/00", p, wr_count);
    end
  endtask

`ifdef INST_PARITY_EN
  task automatic test_parity;
    int p, f;
    bus.i2c_addr_reg = 8'h02;
    step(4);
    parity_flip      = 1'b1;
    bus.i2c_data_reg = 8'h3C;
    watch(12, p, f);
    parity_flip = 1'b0;
    n_checks++;
    if (p !== 1 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_commit: pulses=%0d err=%b expected 1/0", p, parity_err);
    end
    bus.core_rd_en   = 1'b1;
    bus.core_rd_addr = 4'h2;
    step(1);
    n_checks++;
    if (bus.core_rd_data !== 8'h3C || parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_detect: data=%h err=%b expected 3c/1", bus.core_rd_data, parity_err);
    end
    bus.core_rd_addr = 4'h3;
    step(5);
    bus.core_rd_en = 1'b0;
    n_checks++;
    if (parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_sticky: got %b expected 1", parity_err);
    end
    rst_n = 1'b0;
    bus.i2c_data_reg = 8'h00;
    bus.i2c_addr_reg = 8'h00;
    step(1);
    rst_n = 1'b1;
    step(1);
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clear: got %b expected 0", parity_err);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset_initial();
    test_basic_write();
    test_glitch_filter();
    test_out_of_range();
    test_collision_wrap();
    test_reset_mid_settle();
`ifdef INST_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
